// File: rtl/monitor_pkg.sv
// Shared types and defaults for the CPU bus write monitor.
package monitor_pkg;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } trace_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } mon_state_t;

    localparam logic [15:0] DONE_ADDR_DEFAULT  = 16'h00FE;
    localparam logic [7:0]  PASS_CODE_DEFAULT  = 8'h29;
    localparam logic [7:0]  STACK_PAGE_DEFAULT = 8'h01;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/bus_write_monitor_if.sv
// Bus and trace-drain signals between the CPU/bench side and the write monitor.
interface bus_write_monitor_if #(
    parameter int unsigned DEPTH = 16
) ();

    logic [15:0]             address;
    logic [7:0]              data_out;
    logic                    memwrite;
    logic                    trace_pop;
    logic                    trace_valid;
    logic [15:0]             trace_addr;
    logic [7:0]              trace_data;
    logic [$clog2(DEPTH):0]  trace_count;
    logic                    overflow;
    logic [7:0]              stack_writes;
    logic                    done;
    logic                    pass;
    logic [7:0]              result;

    modport master (
        output address, data_out, memwrite, trace_pop,
        input  trace_valid, trace_addr, trace_data, trace_count,
        input  overflow, stack_writes, done, pass, result
    );

    modport slave (
        input  address, data_out, memwrite, trace_pop,
        output trace_valid, trace_addr, trace_data, trace_count,
        output overflow, stack_writes, done, pass, result
    );

endinterface

// File: rtl/trace_fifo.sv
// Synchronous FIFO of trace entries; full/empty come from the occupancy count.
module trace_fifo
    import monitor_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  trace_entry_t           i_entry,
    output trace_entry_t           o_head,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_empty,
    output logic                   o_drop
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    trace_entry_t    r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            w_full;
    logic            w_pop_ok;
    logic            w_push_ok;

    assign o_empty   = (r_count == '0);
    assign w_full    = (r_count == CW'(DEPTH));
    // A pop on an empty FIFO is ignored, so it never frees a slot for a push.
    assign w_pop_ok  = i_pop && !o_empty;
    assign w_push_ok = i_push && (!w_full || w_pop_ok);
    assign o_drop    = i_push && w_full && !w_pop_ok;
    assign o_head    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst && w_push_ok) begin
            r_mem[r_wr_ptr] <= i_entry;
        end
    end

endmodule

// File: rtl/bus_write_monitor.sv
// Passive CPU write monitor: trace FIFO, stack-page write counter and test-end mailbox.
module bus_write_monitor
    import monitor_pkg::*;
#(
    parameter int unsigned DEPTH      = 16,
    parameter logic [15:0] DONE_ADDR  = DONE_ADDR_DEFAULT,
    parameter logic [7:0]  PASS_CODE  = PASS_CODE_DEFAULT,
    parameter logic [7:0]  STACK_PAGE = STACK_PAGE_DEFAULT
) (
    input  logic                ph1,
    input  logic                reset,
    bus_write_monitor_if.slave  bus
);

    mon_state_t             r_state;
    mon_state_t             w_state_next;
    logic                   w_capture;
    logic                   w_mailbox_hit;
    logic                   w_stack_hit;
    trace_entry_t           w_entry;
    trace_entry_t           w_head;
    logic [$clog2(DEPTH):0] w_count;
    logic                   w_empty;
    logic                   w_drop;
    logic                   r_overflow;
    logic [7:0]             r_stack_writes;
    logic                   r_done;
    logic                   r_pass;
    logic [7:0]             r_result;

    always_ff @(posedge ph1) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A mailbox write as the very first write ends the run straight from IDLE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (bus.memwrite) begin
                    w_state_next = (bus.address == DONE_ADDR) ? DONE : RUN;
                end
            end
            RUN: begin
                if (bus.memwrite && (bus.address == DONE_ADDR)) begin
                    w_state_next = DONE;
                end
            end
            DONE:    w_state_next = DONE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_capture     = 1'b0;
        w_mailbox_hit = 1'b0;
        w_stack_hit   = 1'b0;
        w_entry       = '{addr: bus.address, data: bus.data_out};
        if (bus.memwrite && (r_state != DONE)) begin
            w_capture     = 1'b1;
            w_mailbox_hit = (bus.address == DONE_ADDR);
            w_stack_hit   = (bus.address[15:8] == STACK_PAGE);
        end
    end

    trace_fifo #(
        .DEPTH (DEPTH)
    ) u_trace_fifo (
        .i_clk   (ph1),
        .i_rst   (reset),
        .i_push  (w_capture),
        .i_pop   (bus.trace_pop),
        .i_entry (w_entry),
        .o_head  (w_head),
        .o_count (w_count),
        .o_empty (w_empty),
        .o_drop  (w_drop)
    );

    always_ff @(posedge ph1) begin
        if (reset) begin
            r_overflow     <= 1'b0;
            r_stack_writes <= 8'h00;
            r_done         <= 1'b0;
            r_pass         <= 1'b0;
            r_result       <= 8'h00;
        end else begin
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_stack_hit) begin
                r_stack_writes <= sat_inc8(r_stack_writes);
            end
            if (w_mailbox_hit) begin
                r_done   <= 1'b1;
                r_result <= bus.data_out;
                r_pass   <= (bus.data_out == PASS_CODE);
            end
        end
    end

    assign bus.trace_valid  = !w_empty;
    assign bus.trace_addr   = w_empty ? 16'h0000 : w_head.addr;
    assign bus.trace_data   = w_empty ? 8'h00 : w_head.data;
    assign bus.trace_count  = w_count;
    assign bus.overflow     = r_overflow;
    assign bus.stack_writes = r_stack_writes;
    assign bus.done         = r_done;
    assign bus.pass         = r_pass;
    assign bus.result       = r_result;

endmodule
